regprog_sequencer: RTL
======================

Name: regprog_sequencer

Overview:
- Sequential executor for the evolved 4-register bitwise datapath; one instruction per clock from a loadable program memory.
- Lets the search loop swap candidate programs without resynthesis. Each candidate is a list of AND/OR/XOR/logical-NOT ops over r0..r3 and inputs a0,a1,b0,b1.
- Sits between the candidate loader (program writes) and the fitness evaluator (y outputs plus valid strobe).

Parameters:
- W, 16, datapath width of inputs, registers and outputs.
- DEPTH, 64, program memory entries (max program length).
- AW, $clog2(DEPTH), program address width.
- LW, $clog2(DEPTH+1), program length register width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- prog_we  in  1  write strobe for the program memory.
- prog_addr  in  AW  write address.
- prog_data  in  7  instruction, packed as {op[6:5], dst[4:3], src[2:0]}.
- prog_len_we  in  1  loads prog_len from prog_len_in.
- prog_len_in  in  LW  number of instructions to execute.
- start  in  1  begin an evaluation; sampled in IDLE only.
- a1, a0, b1, b0  in  W each  operands, latched when start is accepted.
- busy  out  1  high from start acceptance until y_valid is asserted.
- y_valid  out  1  one-cycle pulse; y3..y0 hold a new result.
- y3, y2, y1, y0  out  W each  result registers, mapped to r3, r2, r1, r0.
- prog_wr_err  out  1  one-cycle pulse when prog_we or prog_len_we arrives while busy.

Behaviour:
- Instruction encoding:
  - op: 0 AND (dst &= s), 1 OR (dst |= s), 2 XOR (dst ^= s), 3 NOT (dst = !s).
  - NOT is logical, not bitwise: the result is W'h0001 when s==0, else W'h0000.
  - src 0-3 select r0-r3; src 4-7 select the latched a0, a1, b0, b1.
- Reset (async, rst high):
  - state=IDLE; r0..r3, y0..y3 = 0; y_valid, busy, prog_wr_err = 0; pc=0; prog_len=0.
  - Program memory is not reset.
  - Reset mid-run aborts immediately; no y_valid is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: r0=a0, r1=a1, r2=b0, r3=b1; operands latched; pc=0; busy=1.
  - Next state is RUN, or DONE if prog_len==0.
- RUN:
  - Each edge executes mem[pc] using the register values from before that edge; pc++.
  - After executing pc==prog_len-1, go to DONE.
- DONE:
  - Next edge: y0..y3 = r0..r3; y_valid=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: with start accepted at edge k, y_valid is high during the cycle after edge k+prog_len+1.
- start is ignored while busy; it is not queued.
- Back-to-back runs: start may be asserted in the same cycle y_valid is high. That cycle is IDLE, so the start is accepted.
- Program writes:
  - prog_we / prog_len_we take effect at the edge when not busy.
  - While busy they are dropped and prog_wr_err pulses for 1 cycle.
- prog_len_in > DEPTH saturates to DEPTH.
- pc never wraps: the maximum is DEPTH-1.
- y0..y3 hold their value until the next y_valid or reset. Operand changes during a run have no effect.

Test Plan:
- Reset values: assert rst mid-cycle with no clk edge -> all outputs are 0 immediately, and busy=0.
- Basic 3-instruction run:
  - Program: [AND r3,a1 = 0b00_11_101; XOR r0,b1 = 0b10_00_111; NOT r1,r1 = 0b11_01_001], len=3.
  - Inputs: a0=0x00F0, a1=0x0F0F, b0=0x1234, b1=0xFFFF.
  - Required: y_valid in the 4th cycle after the start edge, with y3=0x0F0F, y2=0x1234, y1=0x0000, y0=0xFF0F.
- Logical NOT: append NOT r1,r1 (len=4) -> y1=0x0001; y_valid arrives one cycle later than the 3-instruction run.
- Zero length: len=0, a0=0xAAAA, a1=0x5555, b0=0x0001, b1=0x8000 -> y_valid 1 cycle after start; y0..y3 = 0xAAAA, 0x5555, 0x0001, 0x8000.
- Busy protection:
  - Issue prog_we and start during a len=3 run -> prog_wr_err pulses; memory is unchanged (rerun gives the identical result); the second start is ignored.
- Length saturation and reset abort:
  - prog_len_in=DEPTH+1 with DEPTH=64 -> runs 64 instructions; y_valid occurs 65 cycles after start.
  - Assert rst at cycle 10 of that run -> no y_valid, y=0, busy=0.

Source files
------------

// File: rtl/regprog_sequencer.sv
// Loadable-program executor for the evolved 4-register bitwise datapath.
// Runs one AND/OR/XOR/logical-NOT instruction per clock and publishes r0..r3 on y0..y3.
module regprog_sequencer #(
    parameter int W     = 16,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [6:0]    prog_data,
    input  logic          prog_len_we,
    input  logic [LW-1:0] prog_len_in,
    input  logic          start,
    input  logic [W-1:0]  a1,
    input  logic [W-1:0]  a0,
    input  logic [W-1:0]  b1,
    input  logic [W-1:0]  b0,
    output logic          busy,
    output logic          y_valid,
    output logic [W-1:0]  y3,
    output logic [W-1:0]  y2,
    output logic [W-1:0]  y1,
    output logic [W-1:0]  y0,
    output logic          prog_wr_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [6:0]          mem [DEPTH];
    logic [AW-1:0]       pc;
    logic [LW-1:0]       prog_len;
    logic [3:0][W-1:0]   r;
    logic [3:0][W-1:0]   opnd;
    logic [3:0][W-1:0]   y;

    logic [6:0]          instr;
    logic [1:0]          op;
    logic [1:0]          dst;
    logic [2:0]          src;
    logic [W-1:0]        s;
    logic [W-1:0]        res;
    logic                last_instr;

    // NOTE: the program store has no reset so it maps onto plain RAM; programs survive rst.
    always_ff @(posedge clk) begin
        if (prog_we && !busy)
            mem[prog_addr] <= prog_data;
    end

    always_comb begin
        instr      = mem[pc];
        op         = instr[6:5];
        dst        = instr[4:3];
        src        = instr[2:0];
        s          = src[2] ? opnd[src[1:0]] : r[src[1:0]];
        last_instr = (LW'(pc) + LW'(1)) == prog_len;
        unique case (op)
            2'd0:    res = r[dst] & s;
            2'd1:    res = r[dst] | s;
            2'd2:    res = r[dst] ^ s;
            default: res = (s == '0) ? W'(1) : '0;   // logical, not bitwise, NOT
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            prog_len    <= '0;
            r           <= '0;
            opnd        <= '0;
            y           <= '0;
            busy        <= 1'b0;
            y_valid     <= 1'b0;
            prog_wr_err <= 1'b0;
        end else begin
            y_valid     <= 1'b0;
            prog_wr_err <= busy && (prog_we || prog_len_we);

            if (prog_len_we && !busy)
                prog_len <= (prog_len_in > LW'(DEPTH)) ? LW'(DEPTH) : prog_len_in;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        r     <= {b1, b0, a1, a0};
                        opnd  <= {b1, b0, a1, a0};
                        pc    <= '0;
                        busy  <= 1'b1;
                        state <= (prog_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    r[dst] <= res;
                    // Hold pc on the last instruction so it never wraps past DEPTH-1.
                    if (last_instr)
                        state <= DONE;
                    else
                        pc <= pc + AW'(1);
                end
                DONE: begin
                    y       <= r;
                    y_valid <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign y0 = y[0];
    assign y1 = y[1];
    assign y2 = y[2];
    assign y3 = y[3];

endmodule
